// File: rtl/char_row_sequencer_if.sv
// rtl/char_row_sequencer_if.sv - text-row sequencer bus bundle (RAM, generator, pixel FIFO); blink_phase exists only under BLINK_EN
interface char_row_sequencer_if #(parameter int ADDR_W = 11);
  logic              start;
  logic [ADDR_W-1:0] row_base;
  logic [3:0]        ychar;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cg_load;
  logic [3:0]        cg_ychar;
  logic [7:0]        cg_index;
  logic              cg_xsize, cg_ysize, cg_xpart, cg_ypart;
  logic              cg_halftone, cg_underline, cg_invert;
  logic [7:0]        cg_row_pixels;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
`ifdef BLINK_EN
  logic              blink_phase;

  modport master (
    input  start, row_base, ychar, mem_data, cg_row_pixels, pix_ready, blink_phase,
    output busy, done, mem_rd, mem_addr, cg_load, cg_ychar, cg_index, cg_xsize, cg_ysize,
           cg_xpart, cg_ypart, cg_halftone, cg_underline, cg_invert, pix_valid, pix_data
  );
  modport slave (
    output start, row_base, ychar, mem_data, cg_row_pixels, pix_ready, blink_phase,
    input  busy, done, mem_rd, mem_addr, cg_load, cg_ychar, cg_index, cg_xsize, cg_ysize,
           cg_xpart, cg_ypart, cg_halftone, cg_underline, cg_invert, pix_valid, pix_data
  );
`else
  modport master (
    input  start, row_base, ychar, mem_data, cg_row_pixels, pix_ready,
    output busy, done, mem_rd, mem_addr, cg_load, cg_ychar, cg_index, cg_xsize, cg_ysize,
           cg_xpart, cg_ypart, cg_halftone, cg_underline, cg_invert, pix_valid, pix_data
  );
  modport slave (
    output start, row_base, ychar, mem_data, cg_row_pixels, pix_ready,
    input  busy, done, mem_rd, mem_addr, cg_load, cg_ychar, cg_index, cg_xsize, cg_ysize,
           cg_xpart, cg_ypart, cg_halftone, cg_underline, cg_invert, pix_valid, pix_data
  );
`endif
endinterface

// File: rtl/char_row_sequencer.sv
// rtl/char_row_sequencer.sv - walks one text row per scanline, drives the character generator, queues slices; BLINK_EN adds blink
module char_row_sequencer #(
  parameter int COLUMNS    = 80,
  parameter int ADDR_W     = 11,
  parameter int CG_LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  char_row_sequencer_if.master bus
);
  localparam int COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int CNT_W = $clog2(CG_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, FETCH, READ, LOAD, WAIT, PUSH} state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] base;
  logic [3:0]        ychar_q;
  logic [13:0]       word;
  logic              xpart;
  logic              reuse;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q, done_q, mem_rd_q, cg_load_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [7:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop, next_reuse;
  logic [13:0] fetched;

  assign push       = (state == PUSH) && (count != 2'd2);
  assign pop        = bus.pix_ready && (count != 2'd0);
  assign next_reuse = word[8] & ~xpart;

  // Blinking cells collapse to a blank, non-underlined glyph; colours/other attributes survive.
  always_comb begin
    fetched = bus.mem_data[13:0];
`ifdef BLINK_EN
    if (bus.mem_data[14] && !bus.blink_phase) begin
      fetched[7:0] = 8'h20;
      fetched[12]  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      base       <= '0;
      ychar_q    <= '0;
      word       <= '0;
      xpart      <= 1'b0;
      reuse      <= 1'b0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      cg_load_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      cg_load_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          base       <= bus.row_base;
          ychar_q    <= bus.ychar;
          col        <= '0;
          busy_q     <= 1'b1;
          reuse      <= 1'b0;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= bus.row_base;
          state      <= FETCH;
        end
        FETCH: if (reuse) begin
          xpart     <= 1'b1;
          cg_load_q <= 1'b1;
          state     <= LOAD;
        end else begin
          state <= READ;
        end
        READ: begin
          word      <= fetched;
          xpart     <= 1'b0;
          cg_load_q <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          cnt   <= CNT_W'(1);
          state <= (CG_LATENCY == 1) ? PUSH : WAIT;
        end
        // The cg_load cycle counts as the first latency clock.
        WAIT: if (cnt == CNT_W'(CG_LATENCY - 1)) state <= PUSH;
              else cnt <= cnt + CNT_W'(1);
        PUSH: if (push) begin
          if (col == COL_W'(COLUMNS - 1)) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            col        <= col + COL_W'(1);
            reuse      <= next_reuse;
            mem_rd_q   <= ~next_reuse;
            mem_addr_q <= base + ADDR_W'(col) + ADDR_W'(1);
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.cg_row_pixels;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.cg_load      = cg_load_q;
  assign bus.cg_ychar     = ychar_q;
  assign bus.cg_index     = word[7:0];
  assign bus.cg_xsize     = word[8];
  assign bus.cg_ysize     = word[9];
  assign bus.cg_ypart     = word[10];
  assign bus.cg_halftone  = word[11];
  assign bus.cg_underline = word[12];
  assign bus.cg_invert    = word[13];
  assign bus.cg_xpart     = xpart;
  assign bus.pix_valid    = (count != 2'd0);
  assign bus.pix_data     = fifo_mem[rd_ptr];
endmodule

// File: tb/tb_char_row_sequencer.sv
// tb/tb_char_row_sequencer.sv - randomized self-checking bench for char_row_sequencer against a row-level model
module tb_char_row_sequencer;
  localparam int COLUMNS = 4;
  localparam int ADDR_W  = 11;
  localparam int L       = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;

  char_row_sequencer_if #(.ADDR_W(ADDR_W)) bus();
  char_row_sequencer #(.COLUMNS(COLUMNS), .ADDR_W(ADDR_W), .CG_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] ram [0:2047];
  logic [10:0] got_addr[$], exp_addr[$];
  logic [18:0] got_load[$], exp_load[$];
  int          got_load_cyc[$];
  logic [7:0]  got_pix[$], exp_pix[$];

  // Record layout: {ychar, index, xsize, ysize, xpart, ypart, halftone, underline, invert}
  function automatic logic [18:0] pack(input logic [3:0] y, input logic [7:0] idx, input logic xs, ys, xp, yp, ht, ul, inv);
    return {y, idx, xs, ys, xp, yp, ht, ul, inv};
  endfunction
  function automatic logic [7:0] gen_f(input logic [18:0] r);
    return (r[14:7] + {r[18:15], 4'b0}) ^ {1'b0, r[6:0]};
  endfunction
  function automatic logic [18:0] cur_rec();
    return pack(bus.cg_ychar, bus.cg_index, bus.cg_xsize, bus.cg_ysize, bus.cg_xpart, bus.cg_ypart,
                bus.cg_halftone, bus.cg_underline, bus.cg_invert);
  endfunction

  // Text RAM: one-clock read latency
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];

  // Character generator: shows the inverted value until its latency has elapsed
  logic [7:0] gen_val = 8'h00;
  int since_load = 0;
  always @(posedge clk) begin
    if (reset) since_load <= 0;
    else if (bus.cg_load) begin gen_val <= gen_f(cur_rec()); since_load <= 1; end
    else if (since_load > 0 && since_load < L) since_load <= since_load + 1;
  end
  assign bus.cg_row_pixels = (since_load >= L) ? gen_val : ~gen_val;

  always @(negedge clk) begin
    if (bus.mem_rd) got_addr.push_back(bus.mem_addr);
    if (bus.cg_load) begin got_load.push_back(cur_rec()); got_load_cyc.push_back(cyc); end
    if (bus.pix_valid && bus.pix_ready) got_pix.push_back(bus.pix_data);
    if (bus.done) done_cnt++;
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[8] = ($urandom_range(0, 2) == 0);
    return w;
  endfunction

  task automatic fill_row(input logic [10:0] b);
    for (int c = 0; c < COLUMNS; c++) ram[b + 11'(c)] = rand_word();
  endtask

  // Row model: each cell reads its own word unless it is the right half of the previous double-width cell.
  task automatic model_row(input logic [10:0] b, input logic [3:0] y, input logic ph);
    logic [15:0] w;
    logic [18:0] r;
    logic xp;
    bit right_half;
    right_half = 0;
    w = '0;
    for (int c = 0; c < COLUMNS; c++) begin
      if (right_half) xp = 1'b1;
      else begin
        exp_addr.push_back(b + 11'(c));
        w = ram[b + 11'(c)];
`ifdef BLINK_EN
        if (w[14] && !ph) begin w[7:0] = 8'h20; w[12] = 1'b0; end
`endif
        xp = 1'b0;
      end
      r = pack(y, w[7:0], w[8], w[9], xp, w[10], w[11], w[12], w[13]);
      exp_load.push_back(r);
      exp_pix.push_back(gen_f(r));
      right_half = w[8] && !xp;
    end
  endtask

  function automatic string diff_addr();
    if (got_addr.size() != exp_addr.size()) return $sformatf("count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) if (got_addr[i] !== exp_addr[i]) return $sformatf("idx=%0d got=%h exp=%h", i, got_addr[i], exp_addr[i]);
    return "";
  endfunction
  function automatic string diff_load();
    if (got_load.size() != exp_load.size()) return $sformatf("count got=%0d exp=%0d", got_load.size(), exp_load.size());
    foreach (exp_load[i]) if (got_load[i] !== exp_load[i]) return $sformatf("idx=%0d got=%h exp=%h", i, got_load[i], exp_load[i]);
    return "";
  endfunction
  function automatic string diff_pix();
    if (got_pix.size() != exp_pix.size()) return $sformatf("count got=%0d exp=%0d", got_pix.size(), exp_pix.size());
    foreach (exp_pix[i]) if (got_pix[i] !== exp_pix[i]) return $sformatf("idx=%0d got=%h exp=%h", i, got_pix[i], exp_pix[i]);
    return "";
  endfunction

  task automatic clear_mon();
    got_addr.delete(); exp_addr.delete(); got_load.delete(); exp_load.delete();
    got_load_cyc.delete(); got_pix.delete(); exp_pix.delete();
  endtask

  task automatic pulse_start(input logic [10:0] b, input logic [3:0] y);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.row_base = b; bus.ychar = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(posedge clk); n++; end
    #1;
    ok = (done_cnt >= target);
  endtask

  task automatic drain();
    bus.pix_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", bus.mem_rd); end
    checks++; if (bus.cg_load !== 1'b0) begin failures++; $display("FAIL reset_cg_load got=%b exp=0", bus.cg_load); end
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.mem_addr !== 11'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (cur_rec() !== 19'h0) begin failures++; $display("FAIL reset_cg_fields got=%h exp=0", cur_rec()); end
    checks++; if (bus.pix_data !== 8'h0) begin failures++; $display("FAIL reset_pix_data got=%h exp=0", bus.pix_data); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [10:0] b;
    bit ok;
    int d0, gap, want;
    string s;
    b = 11'h100;
    for (int c = 0; c < COLUMNS; c++) begin ram[b + 11'(c)] = rand_word(); ram[b + 11'(c)][8] = 1'b0; end
    clear_mon(); model_row(b, 4'h3, 1'b1); d0 = done_cnt;
    pulse_start(b, 4'h3);
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    drain();
    s = diff_addr(); checks++; if (s != "") begin failures++; $display("FAIL basic_addr %s", s); end
    s = diff_load(); checks++; if (s != "") begin failures++; $display("FAIL basic_load %s", s); end
    s = diff_pix();  checks++; if (s != "") begin failures++; $display("FAIL basic_pix %s", s); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bus.busy); end
    for (int i = 1; i < got_load_cyc.size(); i++) begin
      gap = got_load_cyc[i] - got_load_cyc[i-1]; want = L + 3;
      checks++; if (gap != want) begin failures++; $display("FAIL basic_gap idx=%0d got=%0d exp=%0d", i, gap, want); end
    end
  endtask

  task automatic test_double_width();
    logic [10:0] b;
    bit ok;
    int d0, gap;
    string s;
    b = 11'h200;
    ram[b] = rand_word(); ram[b][8] = 1'b0;
    ram[b + 11'd1] = 16'h0141;
    ram[b + 11'd2] = rand_word();
    ram[b + 11'd3] = rand_word(); ram[b + 11'd3][8] = 1'b1;
    clear_mon(); model_row(b, 4'h9, 1'b1); d0 = done_cnt;
    pulse_start(b, 4'h9);
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL dw_timeout got=no_done exp=done"); end
    drain();
    s = diff_addr(); checks++; if (s != "") begin failures++; $display("FAIL dw_addr %s", s); end
    s = diff_load(); checks++; if (s != "") begin failures++; $display("FAIL dw_load %s", s); end
    s = diff_pix();  checks++; if (s != "") begin failures++; $display("FAIL dw_pix %s", s); end
    checks++; if (got_load.size() < 3 || got_load[1][14:4] !== 11'b01000001_100 || got_load[2][14:4] !== 11'b01000001_101)
      begin failures++; $display("FAIL dw_halves got_n=%0d exp=index 41 xpart 0 then 1", got_load.size()); end
    if (got_load_cyc.size() >= 3) begin
      gap = got_load_cyc[2] - got_load_cyc[1];
      checks++; if (gap != L + 2) begin failures++; $display("FAIL dw_gap got=%0d exp=%0d", gap, L + 2); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL dw_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [10:0] b;
    bit ok;
    int d0;
    string s;
    b = 11'h300;
    fill_row(b); clear_mon(); model_row(b, 4'h5, 1'b1); d0 = done_cnt;
    bus.pix_ready = 1'b0;
    pulse_start(b, 4'h5);
    repeat (COLUMNS * (L + 3) + 30) @(posedge clk);
    #1;
    checks++; if (got_pix.size() != 0) begin failures++; $display("FAIL bp_pops got=%0d exp=0", got_pix.size()); end
    checks++; if (got_load.size() != 3) begin failures++; $display("FAIL bp_loads got=%0d exp=3", got_load.size()); end
    checks++; if (bus.pix_valid !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("FAIL bp_stall got=valid %b busy %b exp=1 1", bus.pix_valid, bus.busy); end
    bus.pix_ready = 1'b1;
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    drain();
    s = diff_load(); checks++; if (s != "") begin failures++; $display("FAIL bp_load %s", s); end
    s = diff_pix();  checks++; if (s != "") begin failures++; $display("FAIL bp_pix %s", s); end
  endtask

  task automatic test_reset_mid_row();
    logic [10:0] b;
    bit ok;
    int d0, n, na;
    string s;
    b = 11'h0F0;
    fill_row(b); clear_mon(); d0 = done_cnt;
    bus.pix_ready = 1'b0;
    pulse_start(b, 4'h2);
    n = 0;
    while (got_load.size() < 3 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++; if (got_load.size() < 3) begin failures++; $display("FAIL rst_reach_col2 got=%0d exp=3", got_load.size()); end
    checks++; if (bus.pix_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", bus.pix_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL rst_pix_valid got=%b exp=0", bus.pix_valid); end
    na = got_addr.size();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL rst_no_done got=%0d exp=%0d", done_cnt, d0); end
    checks++; if (got_addr.size() != na) begin failures++; $display("FAIL rst_idle_reads got=%0d exp=%0d", got_addr.size(), na); end
    bus.pix_ready = 1'b1;
    clear_mon(); model_row(b, 4'h2, 1'b1);
    pulse_start(b, 4'h2);
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_rerun_timeout got=no_done exp=done"); end
    drain();
    s = diff_addr(); checks++; if (s != "") begin failures++; $display("FAIL rst_rerun_addr %s", s); end
    s = diff_pix();  checks++; if (s != "") begin failures++; $display("FAIL rst_rerun_pix %s", s); end
  endtask

  task automatic test_start_while_busy();
    logic [10:0] b;
    bit ok;
    int d0;
    string s;
    b = 11'h050;
    fill_row(b); clear_mon(); model_row(b, 4'h7, 1'b1); d0 = done_cnt;
    pulse_start(b, 4'h7);
    repeat (3) @(posedge clk);
    pulse_start(11'h3FF, 4'hA);
    repeat (9) @(posedge clk);
    pulse_start(11'h123, 4'h1);
    wait_done(d0 + 1, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL swb_timeout got=no_done exp=done"); end
    drain();
    repeat (20) @(posedge clk);
    s = diff_addr(); checks++; if (s != "") begin failures++; $display("FAIL swb_addr %s", s); end
    s = diff_load(); checks++; if (s != "") begin failures++; $display("FAIL swb_load %s", s); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL swb_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b;
    logic [3:0] y;
    logic ph;
    int d0, n;
    string s;
    drain(); clear_mon(); d0 = done_cnt;
    for (int r = 0; r < 6; r++) begin
      b = (r == 2) ? 11'h7FE : 11'($urandom);
      y = 4'($urandom);
      ph = 1'($urandom);
      fill_row(b);
`ifdef BLINK_EN
      bus.blink_phase = ph;
`endif
      model_row(b, y, ph);
      pulse_start(b, y);
      n = 0;
      while (done_cnt < d0 + r + 1 && n < 400) begin @(posedge clk); #1; bus.pix_ready = 1'($urandom); n++; end
      checks++; if (done_cnt < d0 + r + 1) begin failures++; $display("FAIL b2b_timeout row=%0d got=%0d exp=%0d", r, done_cnt - d0, r + 1); end
    end
    drain();
    s = diff_addr(); checks++; if (s != "") begin failures++; $display("FAIL b2b_addr %s", s); end
    s = diff_load(); checks++; if (s != "") begin failures++; $display("FAIL b2b_load %s", s); end
    s = diff_pix();  checks++; if (s != "") begin failures++; $display("FAIL b2b_pix %s", s); end
  endtask

`ifdef BLINK_EN
  task automatic test_blink();
    logic [10:0] b;
    bit ok;
    int d0;
    string s;
    b = 11'h400;
    for (int p = 0; p < 2; p++) begin
      fill_row(b);
      ram[b] = 16'h5041;
      bus.blink_phase = 1'(p);
      clear_mon(); model_row(b, 4'h4, 1'(p)); d0 = done_cnt;
      pulse_start(b, 4'h4);
      wait_done(d0 + 1, 200, ok);
      drain();
      checks++; if (got_load.size() < 1 || got_load[0][14:7] !== ((p == 1) ? 8'h41 : 8'h20) || got_load[0][1] !== 1'(p))
        begin failures++; $display("FAIL blink_cell phase=%0d got=%h exp_index=%h", p, (got_load.size() > 0) ? got_load[0] : 19'h0, (p == 1) ? 8'h41 : 8'h20); end
      s = diff_pix(); checks++; if (s != "") begin failures++; $display("FAIL blink_pix phase=%0d %s", p, s); end
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.row_base = '0; bus.ychar = '0; bus.pix_ready = 1'b1;
`ifdef BLINK_EN
    bus.blink_phase = 1'b1;
`endif
    for (int i = 0; i < 2048; i++) ram[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_double_width();
    test_backpressure();
    test_reset_mid_row();
    test_start_while_busy();
    test_back_to_back();
`ifdef BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
